// File: rtl/j1_io_wb_bridge.sv
// J1 CPU I/O port to Wishbone classic-pipelined master bridge, one transaction in flight.
// Define J1_IO_WB_TIMEOUT_EN to abort transactions not acknowledged within TIMEOUT cycles.
module j1_io_wb_bridge #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        io_busy,
    output logic        io_err,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [15:0] wb_adr,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack,
    input  logic        wb_stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_done;
    logic        w_abort;
    logic        r_we;
    logic [15:0] r_adr;
    logic [15:0] r_dat_o;
    logic [15:0] r_din;

    // The timeout counter is 8 bits wide, so TIMEOUT must fit in it.
    generate
        if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
            $error("j1_io_wb_bridge: TIMEOUT must be in 1..255");
        end
    endgenerate

    // A same-cycle ack only counts once the slave has taken the strobe.
    assign w_accept = (r_state == S_IDLE) && (io_rd || io_wr);
    assign w_done   = ((r_state == S_REQ) && !wb_stall && wb_ack) ||
                      ((r_state == S_WAIT) && wb_ack);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (!wb_stall) begin
                    w_next = wb_ack ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wb_ack) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_adr   <= 16'h0000;
            r_dat_o <= 16'h0000;
            r_din   <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= io_wr;
                r_adr   <= io_addr;
                r_dat_o <= io_dout;
            end
            if (w_done && !r_we) begin
                r_din <= wb_dat_i;
            end else if (w_abort && !r_we) begin
                r_din <= 16'hDEAD;
            end
        end
    end

`ifdef J1_IO_WB_TIMEOUT_EN
    logic [7:0] r_count;
    logic       r_err;

    // An ack in the terminal-count cycle wins over the abort.
    assign w_abort = (r_state != S_IDLE) && !w_done && (r_count == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_abort;
            if (w_accept) begin
                r_count <= 8'd0;
            end else if (r_state != S_IDLE) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign io_err = r_err;
`else
    assign w_abort = 1'b0;
    assign io_err  = 1'b0;
`endif

    assign wb_cyc   = (r_state != S_IDLE);
    assign wb_stb   = (r_state == S_REQ);
    assign io_busy  = (r_state != S_IDLE);
    assign wb_we    = r_we;
    assign wb_adr   = r_adr;
    assign wb_dat_o = r_dat_o;
    assign io_din   = r_din;

endmodule

// File: tb/tb_j1_io_wb_bridge.sv
// Self-checking bench for j1_io_wb_bridge: directed scenarios plus randomized transactions
// checked against a transaction-level model (busy length, strobe count, returned data).
module tb_j1_io_wb_bridge;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;
    logic        io_busy;
    logic        io_err;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [15:0] wb_adr;
    logic [15:0] wb_dat_o;
    logic [15:0] wb_dat_i;
    logic        wb_ack;
    logic        wb_stall;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] expDin;

    j1_io_wb_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .io_addr  (io_addr),
        .io_dout  (io_dout),
        .io_din   (io_din),
        .io_busy  (io_busy),
        .io_err   (io_err),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack   (wb_ack),
        .wb_stall (wb_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One CPU request against a slave that stalls 'stalls' cycles, then acks 'delay' cycles
    // after the accepted strobe (0 = same cycle). The CPU hammers the request lines while busy.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                 input logic [15:0] dout, input int stalls, input int delay,
                                 input logic [15:0] rdata, input string tag);
        int busyCycles = 0;
        int stbCycles = 0;
        int waitCycles = 0;
        io_rd   = rd;
        io_wr   = wr;
        io_addr = addr;
        io_dout = dout;
        @(negedge clk);
        for (int i = 0; i < 40 && io_busy === 1'b1; i++) begin
            busyCycles++;
            io_rd   = 1'($urandom);
            io_wr   = 1'($urandom);
            io_addr = 16'($urandom);
            io_dout = 16'($urandom);
            checkOutput({tag, " cyc"}, 32'(wb_cyc), 32'd1);
            if (wb_stb === 1'b1) begin
                stbCycles++;
                checkOutput({tag, " adr"}, 32'(wb_adr), 32'(addr));
                checkOutput({tag, " we"}, 32'(wb_we), 32'(wr));
                checkOutput({tag, " dat_o"}, 32'(wb_dat_o), 32'(dout));
                wb_stall = (stbCycles <= stalls);
                wb_ack   = !wb_stall && (delay == 0);
            end else begin
                waitCycles++;
                wb_stall = 1'($urandom);
                wb_ack   = (waitCycles == delay);
            end
            wb_dat_i = wb_ack ? rdata : 16'($urandom);
            @(negedge clk);
        end
        io_rd    = 1'b0;
        io_wr    = 1'b0;
        wb_ack   = 1'b0;
        wb_stall = 1'b0;
        if (!wr) begin
            expDin = rdata;
        end
        checkOutput({tag, " busy cycles"}, 32'(busyCycles), 32'(stalls + 1 + delay));
        checkOutput({tag, " stb cycles"}, 32'(stbCycles), 32'(stalls + 1));
        checkOutput({tag, " busy end"}, 32'(io_busy), 32'd0);
        checkOutput({tag, " cyc end"}, 32'(wb_cyc), 32'd0);
        checkOutput({tag, " din"}, 32'(io_din), 32'(expDin));
        checkOutput({tag, " err"}, 32'(io_err), 32'd0);
    endtask

    initial begin
        int cycCount;
        int kind;
        rst      = 1'b0;
        io_rd    = 1'b0;
        io_wr    = 1'b1;
        io_addr  = 16'hFFFF;
        io_dout  = 16'hFFFF;
        wb_dat_i = 16'hFFFF;
        wb_ack   = 1'b1;
        wb_stall = 1'b0;
        expDin   = 16'h0000;

        // Reset with a live request and ack on the pins: everything must read zero.
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset cyc", 32'(wb_cyc), 32'd0);
        checkOutput("reset stb", 32'(wb_stb), 32'd0);
        checkOutput("reset we", 32'(wb_we), 32'd0);
        checkOutput("reset adr", 32'(wb_adr), 32'd0);
        checkOutput("reset dat_o", 32'(wb_dat_o), 32'd0);
        checkOutput("reset din", 32'(io_din), 32'd0);
        checkOutput("reset busy", 32'(io_busy), 32'd0);
        checkOutput("reset err", 32'(io_err), 32'd0);
        io_wr  = 1'b0;
        wb_ack = 1'b0;
        rst    = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 1'b1, 16'h0004, 16'hA5C3, 0, 1, 16'h0BAD, "write");
        applyStimulus(1'b1, 1'b0, 16'h0008, 16'h0000, 0, 1, 16'h1234, "read");

        // Ack while idle must not touch io_din.
        wb_ack   = 1'b1;
        wb_dat_i = 16'hBEEF;
        @(negedge clk);
        wb_ack = 1'b0;
        checkOutput("idle ack din", 32'(io_din), 32'(expDin));
        checkOutput("idle ack busy", 32'(io_busy), 32'd0);
        checkOutput("idle ack cyc", 32'(wb_cyc), 32'd0);

        applyStimulus(1'b1, 1'b0, 16'h00C0, 16'h1111, 3, 1, 16'h4321, "stall");
        applyStimulus(1'b1, 1'b1, 16'h0030, 16'h7E57, 0, 1, 16'hFFFF, "both");
        applyStimulus(1'b1, 1'b0, 16'h0040, 16'h2222, 0, 0, 16'h9876, "sameack");

        for (int t = 0; t < 30; t++) begin
            kind = int'($urandom_range(0, 2));
            applyStimulus(kind != 1, kind != 0, 16'($urandom), 16'($urandom),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          16'($urandom), "rand");
        end

        // Slave never acks.
        io_rd   = 1'b1;
        io_addr = 16'h0010;
        @(negedge clk);
        io_rd    = 1'b0;
        cycCount = 0;
`ifdef J1_IO_WB_TIMEOUT_EN
        for (int i = 0; i < 40 && wb_cyc === 1'b1; i++) begin
            cycCount++;
            checkOutput("timeout err early", 32'(io_err), 32'd0);
            @(negedge clk);
        end
        checkOutput("timeout cyc cycles", 32'(cycCount), 32'(TIMEOUT));
        checkOutput("timeout err pulse", 32'(io_err), 32'd1);
        checkOutput("timeout din", 32'(io_din), 32'hDEAD);
        checkOutput("timeout busy", 32'(io_busy), 32'd0);
        @(negedge clk);
        checkOutput("timeout err single", 32'(io_err), 32'd0);
        expDin = 16'hDEAD;
`else
        for (int i = 0; i < 40; i++) begin
            if (wb_cyc === 1'b1) begin
                cycCount++;
            end
            checkOutput("no-timeout err", 32'(io_err), 32'd0);
            @(negedge clk);
        end
        checkOutput("no-timeout cyc cycles", 32'(cycCount), 32'd40);
        checkOutput("no-timeout busy", 32'(io_busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        expDin = 16'h0000;
        checkOutput("no-timeout recover busy", 32'(io_busy), 32'd0);
`endif

        // Reset while waiting for ack, then a late ack arrives.
        io_rd   = 1'b1;
        io_addr = 16'h0020;
        @(negedge clk);
        io_rd = 1'b0;
        checkOutput("rstwait stb", 32'(wb_stb), 32'd1);
        @(negedge clk);
        checkOutput("rstwait in wait stb", 32'(wb_stb), 32'd0);
        checkOutput("rstwait in wait cyc", 32'(wb_cyc), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstwait cyc", 32'(wb_cyc), 32'd0);
        checkOutput("rstwait stb after", 32'(wb_stb), 32'd0);
        checkOutput("rstwait busy", 32'(io_busy), 32'd0);
        checkOutput("rstwait err", 32'(io_err), 32'd0);
        checkOutput("rstwait din", 32'(io_din), 32'd0);
        rst      = 1'b1;
        wb_ack   = 1'b1;
        wb_dat_i = 16'h5555;
        @(negedge clk);
        wb_ack = 1'b0;
        checkOutput("late ack din", 32'(io_din), 32'd0);
        checkOutput("late ack busy", 32'(io_busy), 32'd0);
        checkOutput("late ack err", 32'(io_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
